// File: rtl/jtvigil_snd_latch_if.sv
// rtl/jtvigil_snd_latch_if.sv - main-to-sound command latch bus bundle
interface jtvigil_snd_latch_if;
  logic       main_latch_cs;
  logic [7:0] main_dout;
  logic       snd_rd_cs;
  logic       snd_ack_cs;
  logic       ym_irq_n;
  logic [7:0] snd_latch;
  logic       snd_int_n;
  logic [7:0] snd_int_vec;
  logic       pending;
  logic       overrun;

  modport master (
    output main_latch_cs, main_dout, snd_rd_cs, snd_ack_cs, ym_irq_n,
    input  snd_latch, snd_int_n, snd_int_vec, pending, overrun
  );

  modport slave (
    input  main_latch_cs, main_dout, snd_rd_cs, snd_ack_cs, ym_irq_n,
    output snd_latch, snd_int_n, snd_int_vec, pending, overrun
  );
endinterface

// File: rtl/jtvigil_snd_latch.sv
// rtl/jtvigil_snd_latch.sv - sound-side command latch with merged Z80 IRQ/RST vector (FIFO option: JTVIGIL_LATCH_FIFO_EN)
module jtvigil_snd_latch #(
  parameter int ACK_ON_RD = 1,
  parameter int FIFO_AW   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  jtvigil_snd_latch_if.slave  bus
);

  logic       wr_cs_q, rd_cs_q, ack_cs_q;
  logic       ym_s1_q, ym_s_q;
  logic       wr_ev, ack_ev;
  logic       overrun_q, overrun_d;
  logic       pending_w;
  logic [7:0] latch_w;
  logic       int_n_q, int_n_d;
  logic [7:0] vec_q, vec_d;

  // One-cycle-delayed copies of the strobes so each assertion makes one event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cs_q  <= 1'b0;
      rd_cs_q  <= 1'b0;
      ack_cs_q <= 1'b0;
    end else begin
      wr_cs_q  <= bus.main_latch_cs;
      rd_cs_q  <= bus.snd_rd_cs;
      ack_cs_q <= bus.snd_ack_cs;
    end
  end

  assign wr_ev  = bus.main_latch_cs & ~wr_cs_q;
  assign ack_ev = (bus.snd_ack_cs & ~ack_cs_q) |
                  ((ACK_ON_RD != 0) & bus.snd_rd_cs & ~rd_cs_q);

  // YM2151 IRQ comes from another timing domain; two flops before use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ym_s1_q <= 1'b1;
      ym_s_q  <= 1'b1;
    end else begin
      ym_s1_q <= bus.ym_irq_n;
      ym_s_q  <= ym_s1_q;
    end
  end

`ifndef JTVIGIL_LATCH_FIFO_EN
  logic [7:0] latch_q, latch_d;
  logic       pending_q, pending_d;

  // FIFO_AW has no effect in the single-register build
  if (FIFO_AW < 1) begin : g_fifo_aw_ignored
  end

  // A write always wins; it only counts as lost data if nobody acked it this cycle
  always_comb begin
    latch_d   = latch_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (wr_ev) begin
      latch_d   = bus.main_dout;
      pending_d = 1'b1;
      if (pending_q && !ack_ev) overrun_d = 1'b1;
    end else if (ack_ev) begin
      pending_d = 1'b0;
    end
  end

  // Single latch register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q   <= 8'h00;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      latch_q   <= latch_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign latch_w   = latch_q;
  assign pending_w = pending_q;
`else
  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         last_q, last_d;
  logic               empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH[FIFO_AW:0]);
  assign pop   = ack_ev & ~empty;
  // A simultaneous pop frees a slot, so a write into a full FIFO still lands
  assign push  = wr_ev & (~full | pop);

  // Pointer/count bookkeeping; pointers wrap naturally at FIFO_AW bits
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_d    = last_q;
    overrun_d = overrun_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (wr_ev && !push)    overrun_d = 1'b1;
  end

  // FIFO storage and control registers; reset also flushes queued data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_q    <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= bus.main_dout;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  // When drained, the CPU keeps seeing the byte it last consumed
  assign latch_w   = empty ? last_q : mem_q[rd_ptr_q];
  assign pending_w = ~empty;
`endif

  // Merge latch and YM requests into one level INT and an RST 18h/28h vector
  always_comb begin
    vec_d = 8'hFF;
    if (pending_w) vec_d[5] = 1'b0;
    if (!ym_s_q)   vec_d[4] = 1'b0;
    int_n_d = ~(pending_w | ~ym_s_q);
  end

  // Interrupt line and vector move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_n_q <= 1'b1;
      vec_q   <= 8'hFF;
    end else begin
      int_n_q <= int_n_d;
      vec_q   <= vec_d;
    end
  end

  assign bus.snd_latch   = latch_w;
  assign bus.pending     = pending_w;
  assign bus.overrun     = overrun_q;
  assign bus.snd_int_n   = int_n_q;
  assign bus.snd_int_vec = vec_q;

endmodule

// File: tb/tb_jtvigil_snd_latch.sv
// tb/tb_jtvigil_snd_latch.sv - directed self-checking bench for jtvigil_snd_latch
module tb_jtvigil_snd_latch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  jtvigil_snd_latch_if bus ();

  jtvigil_snd_latch #(.ACK_ON_RD(1), .FIFO_AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_pulse(input logic [7:0] d);
    bus.main_dout = d; bus.main_latch_cs = 1'b1; tick();
    bus.main_latch_cs = 1'b0; tick();
  endtask

  task automatic ack_pulse();
    bus.snd_ack_cs = 1'b1; tick();
    bus.snd_ack_cs = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.main_latch_cs = 1'b0; bus.main_dout = 8'h00;
    bus.snd_rd_cs = 1'b0; bus.snd_ack_cs = 1'b0; bus.ym_irq_n = 1'b1;
    tick(3);
    n_cmp++; if (bus.snd_latch !== 8'h00) begin n_bad++; $display("FAIL rst_latch got %h want 00", bus.snd_latch); end
    n_cmp++; if (bus.snd_int_n !== 1'b1) begin n_bad++; $display("FAIL rst_int_n got %b want 1", bus.snd_int_n); end
    n_cmp++; if (bus.snd_int_vec !== 8'hFF) begin n_bad++; $display("FAIL rst_vec got %h want FF", bus.snd_int_vec); end
    n_cmp++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL rst_pending got %b want 0", bus.pending); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun got %b want 0", bus.overrun); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_write();
    bus.main_dout = 8'hA5; bus.main_latch_cs = 1'b1;
    tick();
    n_cmp++; if (bus.snd_latch !== 8'hA5) begin n_bad++; $display("FAIL wr_latch got %h want A5", bus.snd_latch); end
    n_cmp++; if (bus.pending !== 1'b1) begin n_bad++; $display("FAIL wr_pending got %b want 1", bus.pending); end
    n_cmp++; if (bus.snd_int_n !== 1'b1) begin n_bad++; $display("FAIL wr_int_early got %b want 1", bus.snd_int_n); end
    bus.main_dout = 8'h5A;
    tick();
    n_cmp++; if (bus.snd_int_n !== 1'b0) begin n_bad++; $display("FAIL wr_int_n got %b want 0", bus.snd_int_n); end
    n_cmp++; if (bus.snd_int_vec !== 8'hDF) begin n_bad++; $display("FAIL wr_vec got %h want DF", bus.snd_int_vec); end
    tick(4);
    n_cmp++; if (bus.snd_latch !== 8'hA5) begin n_bad++; $display("FAIL wr_long_cs got %h want A5", bus.snd_latch); end
    bus.main_latch_cs = 1'b0;
    tick();
  endtask

  task automatic test_ack();
    bus.snd_ack_cs = 1'b1;
    tick();
    n_cmp++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL ack_pending got %b want 0", bus.pending); end
    n_cmp++; if (bus.snd_int_n !== 1'b0) begin n_bad++; $display("FAIL ack_int_hold got %b want 0", bus.snd_int_n); end
    bus.snd_ack_cs = 1'b0;
    tick();
    n_cmp++; if (bus.snd_int_n !== 1'b1) begin n_bad++; $display("FAIL ack_int_n got %b want 1", bus.snd_int_n); end
    n_cmp++; if (bus.snd_int_vec !== 8'hFF) begin n_bad++; $display("FAIL ack_vec got %h want FF", bus.snd_int_vec); end
    n_cmp++; if (bus.snd_latch !== 8'hA5) begin n_bad++; $display("FAIL ack_latch got %h want A5", bus.snd_latch); end
  endtask

  task automatic test_ym_merge();
    bus.ym_irq_n = 1'b0;
    tick(3);
    n_cmp++; if (bus.snd_int_vec !== 8'hEF) begin n_bad++; $display("FAIL ym_vec got %h want EF", bus.snd_int_vec); end
    n_cmp++; if (bus.snd_int_n !== 1'b0) begin n_bad++; $display("FAIL ym_int_n got %b want 0", bus.snd_int_n); end
    write_pulse(8'h3C);
    n_cmp++; if (bus.snd_int_vec !== 8'hCF) begin n_bad++; $display("FAIL ym_both_vec got %h want CF", bus.snd_int_vec); end
    n_cmp++; if (bus.snd_latch !== 8'h3C) begin n_bad++; $display("FAIL ym_latch got %h want 3C", bus.snd_latch); end
    ack_pulse();
    n_cmp++; if (bus.snd_int_vec !== 8'hEF) begin n_bad++; $display("FAIL ym_ack_vec got %h want EF", bus.snd_int_vec); end
    n_cmp++; if (bus.snd_int_n !== 1'b0) begin n_bad++; $display("FAIL ym_ack_int got %b want 0", bus.snd_int_n); end
    bus.ym_irq_n = 1'b1;
    tick(2);
    n_cmp++; if (bus.snd_int_vec !== 8'hEF) begin n_bad++; $display("FAIL ym_sync_lat got %h want EF", bus.snd_int_vec); end
    tick();
    n_cmp++; if (bus.snd_int_vec !== 8'hFF) begin n_bad++; $display("FAIL ym_rel_vec got %h want FF", bus.snd_int_vec); end
    n_cmp++; if (bus.snd_int_n !== 1'b1) begin n_bad++; $display("FAIL ym_rel_int got %b want 1", bus.snd_int_n); end
  endtask

  task automatic test_overrun();
    write_pulse(8'h11);
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_first got %b want 0", bus.overrun); end
    write_pulse(8'h22);
    n_cmp++; if (bus.snd_latch !== 8'h22) begin n_bad++; $display("FAIL ovr_latch got %h want 22", bus.snd_latch); end
    n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got %b want 1", bus.overrun); end
    bus.main_dout = 8'h33; bus.main_latch_cs = 1'b1; bus.snd_ack_cs = 1'b1;
    tick();
    bus.main_latch_cs = 1'b0; bus.snd_ack_cs = 1'b0;
    tick();
    n_cmp++; if (bus.pending !== 1'b1) begin n_bad++; $display("FAIL same_clk_pending got %b want 1", bus.pending); end
    n_cmp++; if (bus.snd_latch !== 8'h33) begin n_bad++; $display("FAIL same_clk_latch got %h want 33", bus.snd_latch); end
  endtask

  task automatic test_rd_ack();
    bus.snd_rd_cs = 1'b1;
    tick();
    n_cmp++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL rd_ack_pending got %b want 0", bus.pending); end
    tick(2);
    bus.snd_rd_cs = 1'b0;
    tick();
    ack_pulse();
    n_cmp++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL idle_ack_pending got %b want 0", bus.pending); end
    n_cmp++; if (bus.snd_latch !== 8'h33) begin n_bad++; $display("FAIL idle_ack_latch got %h want 33", bus.snd_latch); end
    n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", bus.overrun); end
  endtask

  task automatic test_fifo();
    logic [7:0] d;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int k = 1; k <= 5; k++) begin
      d = 8'(k);
      write_pulse(d);
      if (k == 4) begin
        n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL fifo_full_ovr got %b want 0", bus.overrun); end
      end
    end
    n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL fifo_drop_ovr got %b want 1", bus.overrun); end
    for (int k = 1; k <= 4; k++) begin
      d = 8'(k);
      n_cmp++; if (bus.snd_latch !== d) begin n_bad++; $display("FAIL fifo_pop got %h want %h", bus.snd_latch, d); end
      ack_pulse();
    end
    n_cmp++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL fifo_empty got %b want 0", bus.pending); end
    ack_pulse();
    n_cmp++; if (bus.snd_latch !== 8'h04) begin n_bad++; $display("FAIL fifo_hold got %h want 04", bus.snd_latch); end
    for (int k = 0; k < 4; k++) begin
      d = 8'h0A + 8'(k);
      write_pulse(d);
    end
    bus.main_dout = 8'h0E; bus.main_latch_cs = 1'b1; bus.snd_ack_cs = 1'b1;
    tick();
    bus.main_latch_cs = 1'b0; bus.snd_ack_cs = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      d = 8'h0B + 8'(k);
      n_cmp++; if (bus.snd_latch !== d) begin n_bad++; $display("FAIL fifo_full_rw got %h want %h", bus.snd_latch, d); end
      ack_pulse();
    end
    n_cmp++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL fifo_drain got %b want 0", bus.pending); end
  endtask

  task automatic test_reset_mid();
    write_pulse(8'h55);
    write_pulse(8'h66);
    n_cmp++; if (bus.snd_int_n !== 1'b0) begin n_bad++; $display("FAIL mid_pre_int got %b want 0", bus.snd_int_n); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.snd_latch !== 8'h00) begin n_bad++; $display("FAIL mid_latch got %h want 00", bus.snd_latch); end
    n_cmp++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL mid_pending got %b want 0", bus.pending); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL mid_overrun got %b want 0", bus.overrun); end
    n_cmp++; if (bus.snd_int_n !== 1'b1) begin n_bad++; $display("FAIL mid_int_n got %b want 1", bus.snd_int_n); end
    n_cmp++; if (bus.snd_int_vec !== 8'hFF) begin n_bad++; $display("FAIL mid_vec got %h want FF", bus.snd_int_vec); end
    tick();
    rst_n = 1'b1;
    tick();
    ack_pulse();
    n_cmp++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL post_ack_pending got %b want 0", bus.pending); end
    n_cmp++; if (bus.snd_latch !== 8'h00) begin n_bad++; $display("FAIL post_ack_latch got %h want 00", bus.snd_latch); end
    write_pulse(8'h77);
    n_cmp++; if (bus.snd_latch !== 8'h77) begin n_bad++; $display("FAIL post_wr_latch got %h want 77", bus.snd_latch); end
    n_cmp++; if (bus.pending !== 1'b1) begin n_bad++; $display("FAIL post_wr_pending got %b want 1", bus.pending); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_ack();
    test_ym_merge();
`ifdef JTVIGIL_LATCH_FIFO_EN
    test_fifo();
`else
    test_overrun();
    test_rd_ack();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
